imem_fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the pipelined MIPS core. It owns the program counter and drives the read port of the instruction memory (`imem_addr`/`imem_rd`, combinational same-cycle `imem_data`). It buffers fetched words in a small prefetch FIFO and hands them to the IF/ID stage over a valid/ready handshake. It also handles branch/jump redirects, flushing and halt-drain.

---
 rtl/mips_fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 76 +++++++
 rtl/imem_fetch_ctrl.sv | 113 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_fetch_pkg
// Brief    : Shared types and constants for the MIPS instruction-fetch unit.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// Module   : fetch_fifo
// Brief    : Prefetch FIFO of {pc, instr} entries; clear overrides push/pop.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              push,
  input  logic              pop,
  input  logic [31:0]       wr_pc,
  input  logic [31:0]       wr_instr,
  output logic [31:0]       rd_pc,
  output logic [31:0]       rd_instr,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  fetch_entry_t     r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = push & ~clear;
  assign w_do_pop  = pop & ~clear & (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr].pc    <= wr_pc;
      r_mem[r_wr_ptr].instr <= wr_instr;
    end
  end

  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(DEPTH));
  assign rd_pc    = empty ? 32'h0 : r_mem[r_rd_ptr].pc;
  assign rd_instr = empty ? NOP_INSTR : r_mem[r_rd_ptr].instr;

endmodule

`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : imem_fetch_ctrl
// Brief    : PC sequencer and instruction-memory fetch with prefetch buffering.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module imem_fetch_ctrl
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_rd,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic              misalign_err,
  output logic [15:0]       fetch_cnt
);

  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  fetch_state_e       r_state;
  fetch_state_e       w_state_next;
  logic [ADDR_W-1:0]  r_pc;
  logic [15:0]        r_fetch_cnt;
  logic               r_misalign;

  logic               w_pop;
  logic               w_fetch;
  logic [c_cnt_w-1:0] w_fifo_count;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [31:0]        w_rd_pc;

  assign w_pop = id_valid & id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!redirect && run) w_state_next = S_RUN;
      end
      S_RUN: begin
        // A pop frees a slot in the same cycle, so a full FIFO still streams.
        w_fetch = ~redirect & (~w_fifo_full | w_pop);
        if (!run) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (redirect)          w_state_next = S_IDLE;
        else if (run)          w_state_next = S_RUN;
        else if (w_fifo_empty) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_fetch_cnt <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_misalign <= redirect & (|redirect_pc[1:0]);
      if (redirect)     r_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (w_fetch) r_pc <= r_pc + ADDR_W'(4);
      if (w_fetch && (r_fetch_cnt != 16'hFFFF)) r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (redirect),
    .push     (w_fetch),
    .pop      (w_pop),
    .wr_pc    (32'(r_pc)),
    .wr_instr (imem_data),
    .rd_pc    (w_rd_pc),
    .rd_instr (id_instr),
    .count    (w_fifo_count),
    .full     (w_fifo_full),
    .empty    (w_fifo_empty)
  );

  assign imem_rd      = w_fetch;
  assign imem_addr    = r_pc;
  assign id_valid     = ~w_fifo_empty;
  assign id_pc        = ADDR_W'(w_rd_pc);
  assign misalign_err = r_misalign;
  assign fetch_cnt    = r_fetch_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_imem_fetch_ctrl
// Brief    : Self-checking bench for imem_fetch_ctrl against a queue model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_imem_fetch_ctrl;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_rd;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        misalign_err;
  logic [15:0] fetch_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: buffered instructions, next pc, and whether fetching is live.
  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_en;
  int          m_cnt;
  logic        m_mis;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[4:2] == 3'd5) return 32'h0;
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_data = mem_word(imem_addr);

  imem_fetch_ctrl #(
    .ADDR_W   (32),
    .RESET_PC (32'h0),
    .DEPTH    (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_rd      (imem_rd),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .misalign_err (misalign_err),
    .fetch_cnt    (fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc  = 32'h0;
    m_en  = 1'b0;
    m_cnt = 0;
    m_mis = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_imem_rd"},  32'(imem_rd), 32'h0);
    chk({tag, "_addr"},     imem_addr, 32'h0);
    chk({tag, "_valid"},    32'(id_valid), 32'h0);
    chk({tag, "_instr"},    id_instr, 32'h0);
    chk({tag, "_pc"},       id_pc, 32'h0);
    chk({tag, "_misalign"}, 32'(misalign_err), 32'h0);
    chk({tag, "_cnt"},      32'(fetch_cnt), 32'h0);
  endtask

  // One clock cycle: drive inputs, compare outputs, then advance the model.
  task automatic cyc(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic e_valid, e_pop, e_fetch;
    ent_t e;
    @(negedge clk);
    run = r; redirect = rd; redirect_pc = rpc; id_ready = rdy;
    #1;
    e_valid = (m_q.size() > 0);
    e_pop   = e_valid && rdy;
    e_fetch = m_en && !rd && ((m_q.size() < DEPTH) || e_pop);
    chk("imem_rd",  32'(imem_rd), 32'(e_fetch));
    chk("imem_addr", imem_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(e_valid));
    chk("id_instr", id_instr, e_valid ? m_q[0].instr : 32'h0);
    chk("id_pc",    id_pc, e_valid ? m_q[0].pc : 32'h0);
    chk("misalign", 32'(misalign_err), 32'(m_mis));
    chk("fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
    if (rd) begin
      m_q.delete();
      m_pc  = rpc & ~32'h3;
      m_mis = (rpc[1:0] != 2'b00);
      m_en  = m_en && r;
    end else begin
      m_mis = 1'b0;
      if (e_pop) void'(m_q.pop_front());
      if (e_fetch) begin
        e.pc = m_pc; e.instr = mem_word(m_pc);
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
        if (m_cnt < 65535) m_cnt++;
      end
      m_en = r;
    end
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    model_reset();
    #3;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming fetch with the consumer always ready.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

    // Asynchronous reset mid-stream.
    @(negedge clk);
    #2;
    rst_n = 1'b0; run = 1'b0; redirect = 1'b0; id_ready = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Stall from the start, then release.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect while full, then misaligned redirect.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h40, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b1, 32'h42, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect and pop in the same cycle while full.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b1, 32'h100, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

    // Drop run with the FIFO full, drain, then resume.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

    // Redirect while idle only moves the pc.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 32'h0, 1'b1);
    cyc(1'b0, 1'b1, 32'h203, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 32'h0, 1'b1);

    // Randomized traffic, with pc wrap exercised near the top of memory.
    cyc(1'b1, 1'b1, 32'hFFFF_FFF0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      cyc(($urandom_range(0, 7) != 0),
          ($urandom_range(0, 11) == 0),
          $urandom,
          ($urandom_range(0, 9) < 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
